// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg
//   Shared types and default sizes for the audio FFT frame sequencer.
//   fft_seq_state_t : FFT FSM state (IDLE, START, RUN, HOLD)
//   N_POINTS_DEF    : default frame / FFT length
//   DONE_TIMEOUT_DEF: default cycles allowed in RUN before fft_done is declared lost
package fft_seq_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, HOLD} fft_seq_state_t;

    localparam int N_POINTS_DEF     = 512;
    localparam int DONE_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if
//   Bundles the capture, FFT-core, SPI-readout and status signals of the
//   frame sequencer.
//   master : sequencer side (drives write strobes, FFT control, SPI ready, status)
//   slave  : environment side (I2S capture, FFT core, SPI slave, status readers)
//   Optional macro FFT_SEQ_OVERRUN_CNT_EN adds overrun_count[7:0].
interface fft_frame_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int FCNT_W = 16
);
    logic              sample_valid;
    logic              sample_we;
    logic [ADDR_W-1:0] sample_waddr;
    logic              sample_wbank;
    logic              fft_start;
    logic              fft_bank;
    logic              fft_done;
    logic              spi_ready;
    logic              spi_frame_done;
    logic              busy;
    logic              overrun;
    logic              fft_error;
    logic [FCNT_W-1:0] frame_count;
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    logic [7:0]        overrun_count;
`endif

    modport master (
        input  sample_valid, fft_done, spi_frame_done,
`ifdef FFT_SEQ_OVERRUN_CNT_EN
        output overrun_count,
`endif
        output sample_we, sample_waddr, sample_wbank, fft_start, fft_bank,
               spi_ready, busy, overrun, fft_error, frame_count
    );

    modport slave (
        output sample_valid, fft_done, spi_frame_done,
`ifdef FFT_SEQ_OVERRUN_CNT_EN
        input  overrun_count,
`endif
        input  sample_we, sample_waddr, sample_wbank, fft_start, fft_bank,
               spi_ready, busy, overrun, fft_error, frame_count
    );
endinterface

// File: rtl/fft_seq_capture_ctr.sv
// fft_seq_capture_ctr
//   Ping-pong sample buffer write addressing.
//   clk, reset     : clock, synchronous active-high reset
//   sample_valid   : 1-cycle strobe per captured sample
//   accept         : sequencer takes the frame flagged by frame_full this cycle
//   sample_we/waddr/wbank : registered buffer write (one cycle after the strobe)
//   frame_full     : 1-cycle pulse alongside the write of the last address
module fft_seq_capture_ctr
    import fft_seq_pkg::*;
#(
    parameter int N_POINTS = N_POINTS_DEF,
    parameter int ADDR_W   = $clog2(N_POINTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic              accept,
    output logic              sample_we,
    output logic [ADDR_W-1:0] sample_waddr,
    output logic              sample_wbank,
    output logic              frame_full
);
    logic [ADDR_W-1:0] addr;
    logic              bank;
    logic              bank_nxt;

    // A sample arriving in the same cycle the previous frame is accepted
    // already belongs to the other bank.
    always_comb begin
        bank_nxt = bank;
        if (accept) bank_nxt = ~bank;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr         <= '0;
            bank         <= 1'b0;
            sample_we    <= 1'b0;
            sample_waddr <= '0;
            sample_wbank <= 1'b0;
            frame_full   <= 1'b0;
        end else begin
            sample_we  <= sample_valid;
            frame_full <= sample_valid && (addr == ADDR_W'(N_POINTS - 1));
            bank       <= bank_nxt;
            if (sample_valid) begin
                sample_waddr <= addr;
                sample_wbank <= bank_nxt;
                // N_POINTS is a power of two, so the address wraps to 0 after
                // the last write whether or not the frame is accepted.
                addr         <= addr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Sequences I2S capture -> FFT core -> SPI readout over a 2-bank sample buffer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fft_frame_sequencer_if.master (capture writes, fft_start/bank/done,
//                spi_ready/frame_done, busy, overrun, fft_error, frame_count)
//   Optional macro FFT_SEQ_OVERRUN_CNT_EN: saturating 8-bit count of discarded frames
//   on bus.overrun_count.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N_POINTS     = N_POINTS_DEF,
    parameter int ADDR_W       = $clog2(N_POINTS),
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF,
    parameter int FCNT_W       = 16
) (
    input logic                    clk,
    input logic                    reset,
    fft_frame_sequencer_if.master  bus
);
    localparam int WD_W = $clog2(DONE_TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(DONE_TIMEOUT - 1);

    fft_seq_state_t    state;
    logic [WD_W-1:0]   wdog;
    logic              frame_full;
    logic              accept;
    logic              overrun_q;
    logic              fft_error_q;
    logic              fft_bank_q;
    logic [FCNT_W-1:0] frame_count_q;

    // A finished frame can only go to the FFT when nothing is in flight, or
    // when the held result is being released in this very cycle.
    always_comb begin
        accept = frame_full &&
                 ((state == IDLE) || ((state == HOLD) && bus.spi_frame_done));
    end

    fft_seq_capture_ctr #(
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W)
    ) u_capture (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (bus.sample_valid),
        .accept       (accept),
        .sample_we    (bus.sample_we),
        .sample_waddr (bus.sample_waddr),
        .sample_wbank (bus.sample_wbank),
        .frame_full   (frame_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wdog          <= '0;
            overrun_q     <= 1'b0;
            fft_error_q   <= 1'b0;
            fft_bank_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (frame_full && !accept) overrun_q <= 1'b1;
            // The completed bank is the one its last sample was written to.
            if (accept) fft_bank_q <= bus.sample_wbank;
            case (state)
                IDLE:  if (accept) state <= START;
                START: begin
                    state <= RUN;
                    wdog  <= '0;
                end
                RUN: begin
                    if (bus.fft_done) begin
                        state         <= HOLD;
                        frame_count_q <= frame_count_q + FCNT_W'(1);
                    end else if (wdog == WD_MAX) begin
                        state       <= IDLE;
                        fft_error_q <= 1'b1;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                HOLD:    if (bus.spi_frame_done) state <= accept ? START : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fft_start   = (state == START);
    assign bus.busy        = (state != IDLE);
    assign bus.spi_ready   = (state == HOLD);
    assign bus.fft_bank    = fft_bank_q;
    assign bus.overrun     = overrun_q;
    assign bus.fft_error   = fft_error_q;
    assign bus.frame_count = frame_count_q;

`ifdef FFT_SEQ_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            overrun_cnt_q <= '0;
        else if (frame_full && !accept && (overrun_cnt_q != 8'hFF))
            overrun_cnt_q <= overrun_cnt_q + 8'd1;
    end

    assign bus.overrun_count = overrun_cnt_q;
`endif
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
//   Directed table of operations (reset, sample bursts, fft_done, spi_frame_done)
//   with hand-computed expected status after each step, plus exact-cycle checks
//   of write address, fft_start timing and the watchdog. A second instance with
//   DONE_TIMEOUT=64 shares the sample stream and never sees fft_done.
module tb_fft_frame_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.ADDR_W(9), .FCNT_W(16)) bus ();
    fft_frame_sequencer_if #(.ADDR_W(9), .FCNT_W(16)) wbus ();

    fft_frame_sequencer #(.N_POINTS(512), .ADDR_W(9), .DONE_TIMEOUT(4096), .FCNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.master));

    fft_frame_sequencer #(.N_POINTS(512), .ADDR_W(9), .DONE_TIMEOUT(64), .FCNT_W(16)) dut_wd (
        .clk(clk), .reset(reset), .bus(wbus.master));

    assign wbus.sample_valid   = bus.sample_valid;
    assign wbus.fft_done       = 1'b0;
    assign wbus.spi_frame_done = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef enum {OP_RST, OP_FEED, OP_DONE, OP_SPI} op_t;

    // OP_FEED: n samples, gap clk apart; OP_DONE: wait n clk then pulse fft_done.
    typedef struct {
        op_t op;
        int  n;
        int  gap;
        bit  spi_last;    // pulse spi_frame_done alongside frame_full
        bit  exp_start;   // fft_start expected 2 clk after the last sample
        bit  first_bank;
        int  first_addr;
        int  last_addr;
        bit  busy;
        bit  spi_rdy;
        bit  ovr;
        int  fcnt;
        bit  fbank;
        int  ocnt;
    } vec_t;

    function automatic vec_t mk(op_t op, int n, int gap, bit spi_last, bit exp_start,
                                bit first_bank, int first_addr, int last_addr,
                                bit busy, bit spi_rdy, bit ovr, int fcnt, bit fbank, int ocnt);
        vec_t v;
        v.op = op; v.n = n; v.gap = gap; v.spi_last = spi_last; v.exp_start = exp_start;
        v.first_bank = first_bank; v.first_addr = first_addr; v.last_addr = last_addr;
        v.busy = busy; v.spi_rdy = spi_rdy; v.ovr = ovr; v.fcnt = fcnt; v.fbank = fbank;
        v.ocnt = ocnt;
        return v;
    endfunction

    // Watchdog instance: RUN is entered the clk after fft_start and must end
    // 64 clk later with fft_error set.
    int main_starts = 0;
    int wd_starts = 0;
    int wd_k = 0;
    bit wd_armed = 1'b0;

    always @(negedge clk) begin
        if (bus.fft_start) main_starts++;
        if (wbus.fft_start) begin
            wd_starts++;
            wd_k = 0;
            wd_armed = 1'b1;
        end else if (wd_armed) begin
            wd_k++;
            if (wd_k == 64) chk("wd busy last RUN clk", int'(wbus.busy), 1);
            if (wd_k == 65) begin
                chk("wd busy after timeout", int'(wbus.busy), 0);
                chk("wd fft_error after timeout", int'(wbus.fft_error), 1);
                wd_armed = 1'b0;
            end
        end
    end

    vec_t vq[$];
    vec_t v;

    initial begin
        bus.sample_valid   = 1'b0;
        bus.fft_done       = 1'b0;
        bus.spi_frame_done = 1'b0;
        repeat (3) @(negedge clk);

        //                op       n    gap spi st fb fa  la   busy rdy ovr fc fbk ocnt
        vq.push_back(mk(OP_RST,  0,   0,  0,  0, 0, 0,  0,   0,   0,  0,  0, 0,  0));
        vq.push_back(mk(OP_FEED, 512, 4,  0,  1, 0, 0,  511, 1,   0,  0,  0, 0,  0));
        vq.push_back(mk(OP_DONE, 99,  0,  0,  0, 0, 0,  0,   1,   1,  0,  1, 0,  0));
        // frame completes while HOLD: discarded, bank stays 1
        vq.push_back(mk(OP_FEED, 512, 2,  0,  0, 1, 0,  511, 1,   1,  1,  1, 0,  1));
        vq.push_back(mk(OP_FEED, 1,   2,  0,  0, 1, 0,  0,   1,   1,  1,  1, 0,  1));
        vq.push_back(mk(OP_SPI,  0,   0,  0,  0, 0, 0,  0,   0,   0,  1,  1, 0,  1));
        vq.push_back(mk(OP_FEED, 511, 1,  0,  1, 1, 1,  511, 1,   0,  1,  1, 1,  1));
        // reset lands at capture addr 200 with the FFT in RUN
        vq.push_back(mk(OP_FEED, 200, 2,  0,  0, 0, 0,  199, 1,   0,  1,  1, 1,  1));
        vq.push_back(mk(OP_RST,  0,   0,  0,  0, 0, 0,  0,   0,   0,  0,  0, 0,  0));
        vq.push_back(mk(OP_FEED, 512, 1,  0,  1, 0, 0,  511, 1,   0,  0,  0, 0,  0));
        vq.push_back(mk(OP_DONE, 99,  0,  0,  0, 0, 0,  0,   1,   1,  0,  1, 0,  0));
        // spi_frame_done coincides with frame_full: accepted, bank toggles
        vq.push_back(mk(OP_FEED, 512, 1,  1,  1, 1, 0,  511, 1,   0,  0,  1, 1,  0));
        vq.push_back(mk(OP_FEED, 1,   1,  0,  0, 0, 0,  0,   1,   0,  0,  1, 1,  0));
        vq.push_back(mk(OP_DONE, 99,  0,  0,  0, 0, 0,  0,   1,   1,  0,  2, 1,  0));
        vq.push_back(mk(OP_SPI,  0,   0,  0,  0, 0, 0,  0,   0,   0,  0,  2, 1,  0));

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            case (v.op)
                OP_RST: begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    chk($sformatf("v%0d sample_we after reset", i), int'(bus.sample_we), 0);
                    chk($sformatf("v%0d waddr after reset", i), int'(bus.sample_waddr), 0);
                    chk($sformatf("v%0d wbank after reset", i), int'(bus.sample_wbank), 0);
                    chk($sformatf("v%0d fft_start after reset", i), int'(bus.fft_start), 0);
                end
                OP_FEED: begin
                    for (int s = 0; s < v.n; s++) begin
                        bus.sample_valid = 1'b1;
                        @(negedge clk);
                        bus.sample_valid = 1'b0;
                        if (s == 0) begin
                            chk($sformatf("v%0d first sample_we", i), int'(bus.sample_we), 1);
                            chk($sformatf("v%0d first wbank", i), int'(bus.sample_wbank), int'(v.first_bank));
                            chk($sformatf("v%0d first waddr", i), int'(bus.sample_waddr), v.first_addr);
                        end
                        if (s == v.n - 1) begin
                            chk($sformatf("v%0d last waddr", i), int'(bus.sample_waddr), v.last_addr);
                            chk($sformatf("v%0d fft_start early", i), int'(bus.fft_start), 0);
                            if (v.spi_last) bus.spi_frame_done = 1'b1;
                            @(negedge clk);
                            bus.spi_frame_done = 1'b0;
                            chk($sformatf("v%0d fft_start at +2", i), int'(bus.fft_start), int'(v.exp_start));
                            @(negedge clk);
                            chk($sformatf("v%0d fft_start width", i), int'(bus.fft_start), 0);
                        end else begin
                            repeat (v.gap - 1) @(negedge clk);
                        end
                    end
                end
                OP_DONE: begin
                    repeat (v.n) @(negedge clk);
                    chk($sformatf("v%0d spi_ready before done", i), int'(bus.spi_ready), 0);
                    bus.fft_done = 1'b1;
                    @(negedge clk);
                    bus.fft_done = 1'b0;
                end
                OP_SPI: begin
                    bus.spi_frame_done = 1'b1;
                    @(negedge clk);
                    bus.spi_frame_done = 1'b0;
                end
                default: ;
            endcase
            chk($sformatf("v%0d busy", i), int'(bus.busy), int'(v.busy));
            chk($sformatf("v%0d spi_ready", i), int'(bus.spi_ready), int'(v.spi_rdy));
            chk($sformatf("v%0d overrun", i), int'(bus.overrun), int'(v.ovr));
            chk($sformatf("v%0d fft_error", i), int'(bus.fft_error), 0);
            chk($sformatf("v%0d frame_count", i), int'(bus.frame_count), v.fcnt);
            chk($sformatf("v%0d fft_bank", i), int'(bus.fft_bank), int'(v.fbank));
`ifdef FFT_SEQ_OVERRUN_CNT_EN
            chk($sformatf("v%0d overrun_count", i), int'(bus.overrun_count), v.ocnt);
`endif
        end

        repeat (2) @(negedge clk);
        chk("main fft_start pulses", main_starts, 4);
        chk("wd fft_start pulses", wd_starts, 5);
        chk("wd fft_error sticky", int'(wbus.fft_error), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
